// File: rtl/aer_arb_ctrl_pkg.sv
// Shared types and default widths for the AER arbiter-tree root controller.
package aer_arb_ctrl_pkg;

    localparam int N_CH_DEF   = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int TS_W_DEF   = 16;

    // Root handshake phases.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT_RO_LOW,
        ST_DRAIN
    } state_t;

    // Buffered address event. Fields are sized for the default widths;
    // narrower instances zero-extend into them.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [TS_W_DEF-1:0]   ts;
    } evt_t;

endpackage

// File: rtl/aer_evt_fifo.sv
// First-word fall-through event FIFO with valid/ready read side.
module aer_evt_fifo
    import aer_arb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  evt_t i_data,
    output logic o_full,
    output logic o_valid,
    input  logic i_ready,
    output evt_t o_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    evt_t             r_mem [DEPTH];
    logic [PTR_W:0]   w_count;
    logic             w_pop;
    logic             w_wr;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = (w_count == (PTR_W + 1)'(DEPTH));
    assign o_valid = (r_wr_ptr != r_rd_ptr);
    assign w_pop   = o_valid & i_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign w_wr    = i_push & (~o_full | w_pop);
    // Head is forced to zero when empty so the outputs have a defined reset value.
    assign o_data  = o_valid ? r_mem[r_rd_ptr[PTR_W-1:0]] : '0;

    // Pointer update on accepted writes and pops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + (PTR_W + 1)'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
        if (w_wr) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/aer_arb_ctrl.sv
// Synchronous root controller for the asynchronous AER arbiter tree:
// paces the root 4-phase handshake, decodes the winning leaf and buffers
// timestamped address events.
module aer_arb_ctrl
    import aer_arb_ctrl_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TS_W        = TS_W_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              arb_ro,
    output logic              arb_n_ri,
    input  logic [N_CH-1:0]   arb_n_lno,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [ADDR_W-1:0] ev_addr,
    output logic [TS_W-1:0]   ev_ts,
    output logic              busy,
    output logic              err_multi,
    output logic              err_timeout
);

    localparam int TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_ro_sync;
    logic [N_CH-1:0]        r_nl_sync [SYNC_STAGES];
    logic [N_CH-1:0]        r_nl_prev;
    logic [TS_W-1:0]        r_ts;
    state_t                 r_state;
    logic                   r_n_ri;
    logic [TMO_W-1:0]       r_tmo;
    logic [SETTLE_W-1:0]    r_settle;
    logic                   r_err_multi;
    logic                   r_err_tmo;

    logic                   w_ro_s;
    logic [N_CH-1:0]        w_nl_s;
    logic [N_CH-1:0]        w_zeros;
    logic                   w_stable;
    logic                   w_multi;
    logic [ADDR_W-1:0]      w_low_idx;
    logic                   w_push;
    logic                   w_full;
    evt_t                   w_push_evt;
    evt_t                   w_head;

    assign w_ro_s = r_ro_sync[SYNC_STAGES-1];
    assign w_nl_s = r_nl_sync[SYNC_STAGES-1];

    // Synchronizer chains, cleared to the idle handshake levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ro_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_nl_sync[i] <= '1;
        end else begin
            r_ro_sync[0] <= arb_ro;
            r_nl_sync[0] <= arb_n_lno;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_ro_sync[i] <= r_ro_sync[i-1];
                r_nl_sync[i] <= r_nl_sync[i-1];
            end
        end
    end

    // Previous leaf-ack sample and free-running timestamp.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nl_prev <= '1;
            r_ts      <= '0;
        end else begin
            r_nl_prev <= w_nl_s;
            r_ts      <= r_ts + TS_W'(1);
        end
    end

    // A pattern counts once it has held for two cycles; ties resolve to the lowest index.
    assign w_zeros  = ~w_nl_s;
    assign w_stable = (w_nl_s == r_nl_prev) && (w_nl_s != '1);
    assign w_multi  = |(w_zeros & (w_zeros - N_CH'(1)));
    assign w_push   = (r_state == ST_ACK) && w_stable;

    // Lowest low leaf ack and the event to push.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_low_idx  = '0;
        w_push_evt = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_zeros[i]) w_low_idx = ADDR_W'(i);
        end
        w_push_evt.addr = ADDR_W_DEF'(w_low_idx);
        w_push_evt.ts   = TS_W_DEF'(r_ts);
    end

    // Root handshake FSM with registered acknowledge and sticky error flags.
    // r_settle keeps DRAIN from trusting the cleared synchronizers right after reset,
    // so a request still high across reset is not re-acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_DRAIN;
            r_n_ri      <= 1'b1;
            r_tmo       <= '0;
            r_settle    <= SETTLE_W'(SYNC_STAGES);
            r_err_multi <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            if (r_settle != '0) r_settle <= r_settle - SETTLE_W'(1);
            case (r_state)
                ST_IDLE: begin
                    if (w_ro_s && en && !w_full) begin
                        r_state <= ST_ACK;
                        r_n_ri  <= 1'b0;
                        r_tmo   <= '0;
                    end
                end
                ST_ACK: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (w_stable) begin
                        r_err_multi <= r_err_multi | w_multi;
                        r_state     <= ST_WAIT_RO_LOW;
                    end else if (r_tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
                        r_err_tmo <= 1'b1;
                        r_state   <= ST_WAIT_RO_LOW;
                    end
                end
                ST_WAIT_RO_LOW: begin
                    if (!w_ro_s) begin
                        r_state <= ST_DRAIN;
                        r_n_ri  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!w_ro_s && (w_nl_s == '1) && (r_settle == '0)) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_DRAIN;
                    r_n_ri  <= 1'b1;
                end
            endcase
        end
    end

    aer_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_evt),
        .o_full  (w_full),
        .o_valid (ev_valid),
        .i_ready (ev_ready),
        .o_data  (w_head)
    );

    assign arb_n_ri    = r_n_ri;
    assign ev_addr     = w_head.addr[ADDR_W-1:0];
    assign ev_ts       = w_head.ts[TS_W-1:0];
    assign busy        = (r_state != ST_IDLE);
    assign err_multi   = r_err_multi;
    assign err_timeout = r_err_tmo;

endmodule

// File: tb/tb_aer_arb_ctrl.sv
// Self-checking bench for aer_arb_ctrl: a tree-side handshake driver plus an
// event-queue model of what the controller must emit.
module tb_aer_arb_ctrl;

    localparam int N_CH  = 16;
    localparam int TS_W  = 4;
    localparam int SYNC  = 2;
    localparam int TMO   = 63;
    localparam int BOUND = 300;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            arb_ro;
    logic            arb_n_ri;
    logic [N_CH-1:0] arb_n_lno;
    logic            ev_valid;
    logic            ev_ready;
    logic [3:0]      ev_addr;
    logic [TS_W-1:0] ev_ts;
    logic            busy;
    logic            err_multi;
    logic            err_timeout;

    always #5 clk = ~clk;

    aer_arb_ctrl #(
        .TS_W (TS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .arb_ro      (arb_ro),
        .arb_n_ri    (arb_n_ri),
        .arb_n_lno   (arb_n_lno),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_addr     (ev_addr),
        .ev_ts       (ev_ts),
        .busy        (busy),
        .err_multi   (err_multi),
        .err_timeout (err_timeout)
    );

    typedef struct {
        int addr;
        int ts;
    } exp_t;

    exp_t exp_q[$];
    int   got_addr[$];
    int   got_ts[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   tcnt = 0;
    bit   exp_multi = 1'b0;
    bit   exp_tmo = 1'b0;
    int   rdy_mode = 1;
    int   en_mode = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference timestamp: cycles since the last reset edge, free running.
    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else     tcnt <= tcnt + 1;
    end

    // Per-cycle ready/enable stimulus.
    initial begin
        ev_ready = 1'b0;
        en       = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       ev_ready = 1'b0;
                1:       ev_ready = 1'b1;
                default: ev_ready = 1'($urandom_range(0, 1));
            endcase
            case (en_mode)
                0:       en = 1'b0;
                1:       en = 1'b1;
                default: en = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Compare process: every accepted event against the model queue, plus error flags.
    always @(negedge clk) begin
        if (!rst) begin
            check("err_flag_spurious", {30'd0, err_multi & ~exp_multi, err_timeout & ~exp_tmo}, 32'd0);
            if (ev_valid && ev_ready) begin
                got_addr.push_back(int'(ev_addr));
                got_ts.push_back(int'(ev_ts));
                if (exp_q.size() == 0) begin
                    check("unexpected_event", ev_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ev_addr", ev_addr, e.addr);
                    check("ev_ts", ev_ts, e.ts);
                end
            end
        end
    end

    // Raise the root request and wait for the acknowledge; lat = cycles waited.
    task automatic req_and_wait(output int lat);
        arb_ro = 1'b1;
        lat = 0;
        while (arb_n_ri === 1'b1 && lat < BOUND) begin
            tick();
            lat++;
        end
        if (arb_n_ri !== 1'b0) check("ack_wait_bound", arb_n_ri, 0);
    endtask

    // Tree side of the rest of the handshake: drive leaf acks, drop the request,
    // wait for the acknowledge release, release leaves, wait for IDLE.
    task automatic leaf_and_close(input logic [N_CH-1:0] pat, input int lag, input int hold,
                                  output logic ri_before_drop, output int rel);
        int low;
        int zeros;
        int n;
        repeat (lag) tick();
        if (pat != '1) begin
            low   = -1;
            zeros = 0;
            for (int i = 0; i < N_CH; i++) begin
                if (!pat[i]) begin
                    zeros++;
                    if (low < 0) low = i;
                end
            end
            exp_q.push_back('{addr: low, ts: (tcnt + SYNC + 1) % (1 << TS_W)});
            if (zeros > 1) exp_multi = 1'b1;
        end else begin
            exp_tmo = 1'b1;
        end
        arb_n_lno = pat;
        repeat (hold) tick();
        ri_before_drop = arb_n_ri;
        arb_ro = 1'b0;
        rel = 0;
        while (arb_n_ri !== 1'b1 && rel < BOUND) begin
            tick();
            rel++;
        end
        if (arb_n_ri !== 1'b1) check("ri_release_bound", arb_n_ri, 1);
        arb_n_lno = '1;
        n = 0;
        while (busy !== 1'b0 && n < BOUND) begin
            tick();
            n++;
        end
        check("idle_after_handshake", busy, 0);
        check("err_multi", err_multi, exp_multi);
        check("err_timeout", err_timeout, exp_tmo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   rel;
        int   n;
        int   start;
        bit   held;
        logic rb;
        logic [N_CH-1:0] pat;
        int   bp_exp[5];

        arb_ro    = 1'b0;
        arb_n_lno = '1;
        rst       = 1'b1;
        repeat (3) tick();

        // Reset state.
        check("rst_arb_n_ri", arb_n_ri, 1);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_addr", ev_addr, 0);
        check("rst_ev_ts", ev_ts, 0);
        check("rst_busy", busy, 1);
        check("rst_err_multi", err_multi, 0);
        check("rst_err_timeout", err_timeout, 0);
        rst = 1'b0;
        repeat (5) tick();
        check("idle_after_reset", busy, 0);

        // Single event on channel 9 with hand-computed timing.
        req_and_wait(lat);
        check("ack_latency", lat, 3);
        leaf_and_close(~(16'h0001 << 9), 0, 8, rb, rel);
        check("ri_held_until_ro_low", rb, 0);
        check("ri_release_latency", rel, 3);
        repeat (3) tick();
        check("single_count", got_addr.size(), 1);
        check("single_addr_lit", got_addr[0], 9);
        check("single_ts_lit", got_ts[0], 11);

        // Multi-ack: bits 2 and 3 low.
        got_addr.delete();
        req_and_wait(lat);
        leaf_and_close(16'hFFF3, 1, 4, rb, rel);
        repeat (3) tick();
        check("multi_flag_lit", err_multi, 1);
        check("multi_addr_lit", got_addr[0], 2);

        // Timeout: no leaf ever answers.
        got_addr.delete();
        req_and_wait(lat);
        exp_tmo = 1'b1;
        n = 0;
        while (err_timeout !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TMO);
        check("ri_low_after_timeout", arb_n_ri, 0);
        leaf_and_close('1, 0, 0, rb, rel);
        repeat (3) tick();
        check("timeout_no_event", got_addr.size(), 0);
        check("timeout_fifo_empty", ev_valid, 0);

        // Reset mid-handshake with an event pending.
        rdy_mode = 0;
        req_and_wait(lat);
        leaf_and_close(~(16'h0001 << 6), 1, 2, rb, rel);
        check("pending_event", ev_valid, 1);
        req_and_wait(lat);
        rst = 1'b1;
        exp_q.delete();
        exp_multi = 1'b0;
        exp_tmo   = 1'b0;
        tick();
        check("midrst_arb_n_ri", arb_n_ri, 1);
        check("midrst_fifo_empty", ev_valid, 0);
        check("midrst_busy", busy, 1);
        check("midrst_err_multi", err_multi, 0);
        check("midrst_err_timeout", err_timeout, 0);
        rst = 1'b0;
        held = 1'b1;
        repeat (20) begin
            tick();
            if (arb_n_ri !== 1'b1) held = 1'b0;
        end
        check("no_reack_while_ro_high", held, 1);
        arb_ro = 1'b0;
        repeat (5) tick();
        rdy_mode = 1;
        req_and_wait(lat);
        check("reack_latency", lat, 3);
        leaf_and_close(~(16'h0001 << 12), 2, 3, rb, rel);

        // Back-pressure: fill the FIFO, then a fifth request must wait for one pop.
        repeat (4) tick();
        got_addr.delete();
        rdy_mode = 0;
        tick();
        foreach (bp_exp[i]) bp_exp[i] = 0;
        bp_exp[0] = 0;  bp_exp[1] = 5;  bp_exp[2] = 10;  bp_exp[3] = 15;  bp_exp[4] = 7;
        for (int i = 0; i < 4; i++) begin
            req_and_wait(lat);
            leaf_and_close(~(16'h0001 << bp_exp[i]), $urandom_range(0, 5), 2, rb, rel);
        end
        check("bp_full_valid", ev_valid, 1);
        arb_ro = 1'b1;
        held = 1'b1;
        repeat (20) begin
            tick();
            if (arb_n_ri !== 1'b1) held = 1'b0;
        end
        check("bp_ri_held", held, 1);
        rdy_mode = 1;
        tick();
        rdy_mode = 0;
        req_and_wait(lat);
        leaf_and_close(~(16'h0001 << bp_exp[4]), 1, 2, rb, rel);
        rdy_mode = 1;
        repeat (10) tick();
        check("bp_count", got_addr.size(), 5);
        for (int i = 0; i < 5; i++) check("bp_order_lit", got_addr[i], bp_exp[i]);

        // Enable low blocks the start of a handshake.
        en_mode = 0;
        arb_ro = 1'b1;
        held = 1'b1;
        repeat (15) begin
            tick();
            if (arb_n_ri !== 1'b1) held = 1'b0;
        end
        check("en_low_blocks", held, 1);
        en_mode = 1;
        req_and_wait(lat);
        leaf_and_close(~(16'h0001 << 3), 0, 3, rb, rel);

        // Timestamp wrap: three events 26 cycles apart differ by 10 modulo 16.
        repeat (4) tick();
        got_ts.delete();
        start = tcnt + 2;
        for (int i = 0; i < 3; i++) begin
            while (tcnt < start + 26 * i) tick();
            req_and_wait(lat);
            leaf_and_close(~(16'h0001 << (i + 1)), 0, 6, rb, rel);
        end
        repeat (6) tick();
        check("wrap_count", got_ts.size(), 3);
        check("wrap_delta_0", (got_ts[1] - got_ts[0]) & 15, 10);
        check("wrap_delta_1", (got_ts[2] - got_ts[1]) & 15, 10);

        // Randomized handshakes with random ready and enable.
        rdy_mode = 2;
        en_mode  = 2;
        for (int it = 0; it < 30; it++) begin
            pat = ~(16'h0001 << $urandom_range(0, N_CH - 1));
            if ($urandom_range(0, 7) == 0) pat[$urandom_range(0, N_CH - 1)] = 1'b0;
            req_and_wait(lat);
            leaf_and_close(pat, $urandom_range(0, 12), $urandom_range(0, 8), rb, rel);
        end
        rdy_mode = 1;
        en_mode  = 1;
        repeat (12) tick();
        check("model_drained", exp_q.size(), 0);
        check("fifo_drained", ev_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
